clk_div_ctrl: RTL

Programmable clock-divider controller. Owns the rollover counter that feeds the toggle-clock stage and sequences start, stop and divisor changes so the derived clock never glitches. A clean stop always parks the derived clock high. Sits between the system clock domain and every consumer of the divided clock/rollover pulse.

---
 rtl/clk_div_ctrl_if.sv | 14 +
 rtl/clk_div_ctrl.sv | 128 ++++++++++++
 2 files changed

// File: rtl/clk_div_ctrl_if.sv
// Divisor offer channel for clk_div_ctrl.
// Handshake: the master holds i_div stable while i_div_valid is high; a value
// transfers at a rising edge where i_div_valid and o_div_ready are both high.
// o_div_ready does not depend on i_div_valid in the same cycle.
interface clk_div_ctrl_if #(
  parameter int N_BITS = 8
) ();
  logic [N_BITS-1:0] i_div;
  logic              i_div_valid;
  logic              o_div_ready;

  modport master (output i_div, output i_div_valid, input o_div_ready);
  modport slave  (input i_div, input i_div_valid, output o_div_ready);
endinterface

// File: rtl/clk_div_ctrl.sv
// Programmable clock-divider controller: rollover counter, derived toggle clock,
// and glitch-free sequencing of start, stop and divisor changes.
// A stop only completes on the wrap that drives o_clk high, so the derived
// clock always parks high. New divisors are applied only while the counter
// is returning to zero, so the count can never sit above the active divisor.
module clk_div_ctrl #(
  parameter int N_BITS    = 8,
  parameter int DIV_RESET = 3
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_start,
  input  logic              i_stop,
  clk_div_ctrl_if.slave     div_if,
  output logic              o_roll_over,
  output logic              o_clk,
  output logic              o_running,
  output logic [N_BITS-1:0] o_count,
  output logic [1:0]        o_state
);

  localparam logic [1:0] ST_IDLE  = 2'b00;
  localparam logic [1:0] ST_RUN   = 2'b01;
  localparam logic [1:0] ST_DRAIN = 2'b10;

  localparam logic [N_BITS-1:0] DIV_INIT = N_BITS'(DIV_RESET);

  logic [1:0]        state_q, state_d;
  logic [N_BITS-1:0] count_q, count_d;
  logic [N_BITS-1:0] div_active_q, div_active_d;
  logic [N_BITS-1:0] pend_q, pend_d;
  logic              pend_valid_q, pend_valid_d;
  logic              clk_q, clk_d;
  logic              roll_q, roll_d;
  logic              running_q, running_d;

  logic counting;
  logic wrap;
  logic accept;

  // Counter wrap detection and divisor-offer acceptance.
  always_comb begin
    counting = (state_q != ST_IDLE);
    wrap     = counting && (count_q == div_active_q);
    accept   = div_if.i_div_valid && !pend_valid_q;
  end

  // Next-state logic for the FSM, counter, derived clock and divisor slots.
  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    clk_d        = clk_q;
    roll_d       = wrap;
    div_active_d = div_active_q;
    pend_d       = pend_q;
    pend_valid_d = pend_valid_q;

    if (!counting) begin
      count_d = '0;
      clk_d   = 1'b1;
    end else if (wrap) begin
      count_d = '0;
      clk_d   = ~clk_q;
    end else begin
      count_d = count_q + 1'b1;
    end

    case (state_q)
      ST_IDLE:  if (i_start && !i_stop) state_d = ST_RUN;
      ST_RUN:   if (i_stop) state_d = ST_DRAIN;
      ST_DRAIN: begin
        // A restart keeps the waveform running; otherwise park on the rising wrap.
        if (i_start && !i_stop)  state_d = ST_RUN;
        else if (wrap && !clk_q) state_d = ST_IDLE;
      end
      default:  state_d = ST_IDLE;
    endcase

    if (!counting) begin
      if (accept) div_active_d = div_if.i_div;
    end else begin
      if (wrap && pend_valid_q) begin
        div_active_d = pend_q;
        pend_valid_d = 1'b0;
      end
      if (accept) begin
        pend_d       = div_if.i_div;
        pend_valid_d = 1'b1;
      end
    end

    running_d = (state_d != ST_IDLE);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge i_clk) begin
    if (!i_reset) begin
      state_q      <= ST_IDLE;
      count_q      <= '0;
      div_active_q <= DIV_INIT;
      pend_q       <= '0;
      pend_valid_q <= 1'b0;
      clk_q        <= 1'b1;
      roll_q       <= 1'b0;
      running_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      div_active_q <= div_active_d;
      pend_q       <= pend_d;
      pend_valid_q <= pend_valid_d;
      clk_q        <= clk_d;
      roll_q       <= roll_d;
      running_q    <= running_d;
    end
  end

  // All outputs come straight from registers.
  always_comb begin
    o_roll_over        = roll_q;
    o_clk              = clk_q;
    o_running          = running_q;
    o_count            = count_q;
    o_state            = state_q;
    div_if.o_div_ready = !pend_valid_q;
  end

endmodule
